// File: rtl/stall_pkg.sv
// stall_pkg
// Shared definitions for the pipeline stall controller.
//   stall_state_t    : controller state encoding (RUN, STALL, DRAIN)
//   STALL_CYCLES_W   : width of the saturating stalled-cycle counter
package stall_pkg;

    // Width of the stalled-cycle statistics counter exposed on stall_cycles.
    localparam int STALL_CYCLES_W = 16;

    // RUN   : pipeline flowing, stall_out low
    // STALL : global stall asserted, held for a minimum number of cycles
    // DRAIN : requesters released, stall held until the skid buffer empties
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_DRAIN = 2'd2
    } stall_state_t;

endpackage

// File: rtl/stall_prio_enc.sv
// stall_prio_enc
// Lowest-index-wins one-hot priority encoder.
// Ports:
//   req    [NUM_REQ-1:0] : request vector, any number of bits set
//   onehot [NUM_REQ-1:0] : only the lowest set bit of req; zero when req is zero
module stall_prio_enc #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] onehot
);

    // Two's complement trick: req & -req isolates the lowest set bit.
    assign onehot = req & (~req + NUM_REQ'(1));

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl
// Global pipeline stall controller with skid-buffer occupancy tracking.
// Ports:
//   clk          : clock, all state on rising edge
//   reset        : synchronous active-high reset
//   stall_req    : per-source level stall requests
//   in_valid     : upstream presents a beat
//   out_ready    : downstream accepts a beat
//   stall_out    : registered global stall
//   stall_src    : one-hot source that opened the current episode (0 = buffer full)
//   buf_wr_en    : skid buffer write strobe (combinational)
//   buf_rd_en    : skid buffer read strobe (combinational)
//   buf_count    : skid buffer occupancy
//   buf_full     : occupancy equals BUF_DEPTH
//   overflow     : sticky, a beat arrived while the buffer was full and not draining
//   stall_cycles : saturating count of stalled cycles
module stall_ctrl
    import stall_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BUF_DEPTH = 4,
    parameter int MIN_STALL = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               stall_req,
    input  logic                             in_valid,
    input  logic                             out_ready,
    output logic                             stall_out,
    output logic [NUM_REQ-1:0]               stall_src,
    output logic                             buf_wr_en,
    output logic                             buf_rd_en,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_count,
    output logic                             buf_full,
    output logic                             overflow,
    output logic [STALL_CYCLES_W-1:0]        stall_cycles
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int SC_W  = $clog2(MIN_STALL + 1);

    // The stall counter holds the number of completed STALL cycles, so the
    // current cycle is the MIN_STALL-th one once it reaches MIN_STALL-1.
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(MIN_STALL - 1);
    localparam logic [SC_W-1:0] SC_SAT  = SC_W'(MIN_STALL);

    stall_state_t            state;
    stall_state_t            state_next;
    logic [SC_W-1:0]         stall_cnt;
    logic [CNT_W-1:0]        count_next;
    logic [NUM_REQ-1:0]      prio_onehot;
    logic                    any_req;
    logic                    buf_nonempty;
    logic                    min_met;

    stall_prio_enc #(
        .NUM_REQ (NUM_REQ)
    ) u_prio (
        .req    (stall_req),
        .onehot (prio_onehot)
    );

    assign any_req      = |stall_req;
    assign buf_nonempty = (buf_count != '0);
    assign buf_full     = (buf_count == CNT_W'(BUF_DEPTH));
    assign min_met      = (stall_cnt >= SC_LAST);

    // A beat is parked in the skid buffer whenever it cannot bypass straight
    // to the output: downstream busy, older beats queued, or pipeline stalled.
    assign buf_wr_en = ~reset & in_valid & ~buf_full
                     & (~out_ready | buf_nonempty | stall_out);
    assign buf_rd_en = ~reset & out_ready & buf_nonempty;

    // Occupancy update; strobes already guarantee no overflow or underflow.
    always_comb begin
        count_next = buf_count;
        if (buf_wr_en && !buf_rd_en) begin
            count_next = buf_count + CNT_W'(1);
        end else if (!buf_wr_en && buf_rd_en) begin
            count_next = buf_count - CNT_W'(1);
        end
    end

    // Next-state logic. DRAIN exits on the cycle the last beat is read so
    // the pipeline restarts with an empty buffer.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (any_req || buf_full) begin
                    state_next = ST_STALL;
                end
            end
            ST_STALL: begin
                if (!any_req && min_met) begin
                    state_next = buf_nonempty ? ST_DRAIN : ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (any_req) begin
                    state_next = ST_STALL;
                end else if (count_next == '0) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // State, stall output, episode source and minimum-stall counter.
    // stall_src only changes when a fresh episode opens from RUN; a re-stall
    // out of DRAIN keeps the original source.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            stall_out <= 1'b0;
            stall_src <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_next;
            stall_out <= (state_next != ST_RUN);
            if (state == ST_RUN && state_next == ST_STALL) begin
                stall_src <= prio_onehot;
            end
            if (state_next == ST_STALL && state != ST_STALL) begin
                stall_cnt <= '0;
            end else if (state == ST_STALL && stall_cnt != SC_SAT) begin
                stall_cnt <= stall_cnt + SC_W'(1);
            end
        end
    end

    // Buffer occupancy, sticky overflow and stalled-cycle statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_count    <= '0;
            overflow     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            buf_count <= count_next;
            if (in_valid && buf_full && !buf_rd_en) begin
                overflow <= 1'b1;
            end
            if (stall_out && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + STALL_CYCLES_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl
// Directed testbench for stall_ctrl with hand-computed expectations.
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  stall_req;
    logic        in_valid;
    logic        out_ready;
    logic        stall_out;
    logic [3:0]  stall_src;
    logic        buf_wr_en;
    logic        buf_rd_en;
    logic [2:0]  buf_count;
    logic        buf_full;
    logic        overflow;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // 10 ns clock
    always #5 clk = ~clk;

    stall_ctrl #(
        .NUM_REQ   (4),
        .BUF_DEPTH (4),
        .MIN_STALL (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_req    (stall_req),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .stall_out    (stall_out),
        .stall_src    (stall_src),
        .buf_wr_en    (buf_wr_en),
        .buf_rd_en    (buf_rd_en),
        .buf_count    (buf_count),
        .buf_full     (buf_full),
        .overflow     (overflow),
        .stall_cycles (stall_cycles)
    );

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive every input at once.
    task automatic applyStimulus(input logic rst, input logic [3:0] req, input logic iv, input logic ordy);
        reset     = rst;
        stall_req = req;
        in_valid  = iv;
        out_ready = ordy;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence; each block notes which edge it lands on.
    initial begin
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
        step();
        step();
        checkOutput("rst_stall_out", 32'(stall_out), 32'd0);
        checkOutput("rst_stall_src", 32'(stall_src), 32'd0);
        checkOutput("rst_buf_count", 32'(buf_count), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        checkOutput("rst_wr_en", 32'(buf_wr_en), 32'd0);

        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        step();

        // Single-cycle request: stall for exactly two cycles.
        applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0);
        step();
        checkOutput("single_stall_rise", 32'(stall_out), 32'd1);
        checkOutput("single_src", 32'(stall_src), 32'b0100);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        step();
        checkOutput("single_stall_hold", 32'(stall_out), 32'd1);
        step();
        checkOutput("single_stall_fall", 32'(stall_out), 32'd0);
        checkOutput("single_cycles", 32'(stall_cycles), 32'd2);

        // Simultaneous requests: lowest index wins.
        applyStimulus(1'b0, 4'b1010, 1'b0, 1'b0);
        step();
        checkOutput("simul_stall", 32'(stall_out), 32'd1);
        checkOutput("simul_src", 32'(stall_src), 32'b0010);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        step();
        step();
        checkOutput("simul_release", 32'(stall_out), 32'd0);
        checkOutput("simul_cycles", 32'(stall_cycles), 32'd4);

        // Skid fill: four beats fill the buffer, fifth overflows and stalls.
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        #1;
        checkOutput("fill_wr_en", 32'(buf_wr_en), 32'd1);
        repeat (4) step();
        checkOutput("fill_count4", 32'(buf_count), 32'd4);
        checkOutput("fill_full", 32'(buf_full), 32'd1);
        checkOutput("fill_wr_blocked", 32'(buf_wr_en), 32'd0);
        checkOutput("fill_no_stall_yet", 32'(stall_out), 32'd0);
        checkOutput("fill_no_ovf_yet", 32'(overflow), 32'd0);
        step();
        checkOutput("fill_overflow", 32'(overflow), 32'd1);
        checkOutput("fill_stall", 32'(stall_out), 32'd1);
        checkOutput("fill_src_zero", 32'(stall_src), 32'd0);
        checkOutput("fill_count_hold", 32'(buf_count), 32'd4);

        // Read one beat while stalled, then let STALL exit into DRAIN at 3.
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
        #1;
        checkOutput("stall_rd_en", 32'(buf_rd_en), 32'd1);
        step();
        checkOutput("stall_read_count", 32'(buf_count), 32'd3);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        step();
        checkOutput("drain_entry_count", 32'(buf_count), 32'd3);
        checkOutput("drain_entry_stall", 32'(stall_out), 32'd1);

        // Drain three beats; RUN on the cycle the count reaches zero.
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
        step();
        checkOutput("drain_count2", 32'(buf_count), 32'd2);
        checkOutput("drain_stall2", 32'(stall_out), 32'd1);
        step();
        checkOutput("drain_count1", 32'(buf_count), 32'd1);
        checkOutput("drain_stall1", 32'(stall_out), 32'd1);
        step();
        checkOutput("drain_count0", 32'(buf_count), 32'd0);
        checkOutput("drain_run", 32'(stall_out), 32'd0);
        checkOutput("drain_cycles", 32'(stall_cycles), 32'd9);

        // Re-stall during DRAIN keeps the source and restarts the minimum.
        applyStimulus(1'b0, 4'b1000, 1'b1, 1'b0);
        step();
        checkOutput("restall_open_src", 32'(stall_src), 32'b1000);
        checkOutput("restall_open_count", 32'(buf_count), 32'd1);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        step();
        checkOutput("restall_count2", 32'(buf_count), 32'd2);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
        step();
        checkOutput("restall_drain_count", 32'(buf_count), 32'd1);
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b1);
        step();
        checkOutput("restall_stall", 32'(stall_out), 32'd1);
        checkOutput("restall_src_kept", 32'(stall_src), 32'b1000);
        checkOutput("restall_count0", 32'(buf_count), 32'd0);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        step();
        checkOutput("restall_min_hold", 32'(stall_out), 32'd1);
        step();
        checkOutput("restall_run", 32'(stall_out), 32'd0);
        checkOutput("restall_cycles", 32'(stall_cycles), 32'd15);

        // Reset mid-STALL with two beats buffered.
        applyStimulus(1'b0, 4'b0001, 1'b1, 1'b0);
        step();
        step();
        checkOutput("midrst_pre_count", 32'(buf_count), 32'd2);
        checkOutput("midrst_pre_stall", 32'(stall_out), 32'd1);
        applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0);
        #1;
        checkOutput("midrst_wr_strobe", 32'(buf_wr_en), 32'd0);
        step();
        checkOutput("midrst_stall", 32'(stall_out), 32'd0);
        checkOutput("midrst_count", 32'(buf_count), 32'd0);
        checkOutput("midrst_cycles", 32'(stall_cycles), 32'd0);
        checkOutput("midrst_src", 32'(stall_src), 32'd0);
        checkOutput("midrst_overflow", 32'(overflow), 32'd0);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        step();
        checkOutput("postrst_run", 32'(stall_out), 32'd0);

        // Bypass with empty buffer, then simultaneous read and write.
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
        #1;
        checkOutput("bypass_wr_en", 32'(buf_wr_en), 32'd0);
        checkOutput("bypass_rd_en", 32'(buf_rd_en), 32'd0);
        step();
        checkOutput("bypass_count", 32'(buf_count), 32'd0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        step();
        checkOutput("park_count", 32'(buf_count), 32'd1);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
        #1;
        checkOutput("rw_wr_en", 32'(buf_wr_en), 32'd1);
        checkOutput("rw_rd_en", 32'(buf_rd_en), 32'd1);
        step();
        checkOutput("rw_count_same", 32'(buf_count), 32'd1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
        step();
        checkOutput("rw_empty", 32'(buf_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 4: number of stall requesters.
REQ-002 Parameter BUF_DEPTH, default 4: skid-buffer entries tracked; integer power of two, at least 2.
REQ-003 Parameter MIN_STALL, default 2: minimum cycles spent in STALL per episode.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall_req  input  NUM_REQ  per-source stall request, level-sensitive.
REQ-007 in_valid  input  1  upstream stage presents a beat this cycle.
REQ-008 out_ready  input  1  downstream stage accepts a beat this cycle.
REQ-009 stall_out  output  1  registered global stall to all pipeline stages.
REQ-010 stall_src  output  NUM_REQ  one-hot source that opened the current episode; zero if the episode was opened by buf_full.
REQ-011 buf_wr_en  output  1  combinational write strobe to the skid buffer.
REQ-012 buf_rd_en  output  1  combinational read strobe to the skid buffer.
REQ-013 buf_count  output  clog2(BUF_DEPTH+1)  current skid-buffer occupancy.
REQ-014 buf_full  output  1  combinational, equals (buf_count == BUF_DEPTH).
REQ-015 overflow  output  1  sticky: a write was attempted while the buffer was full.
REQ-016 stall_cycles  output  16  saturating count of cycles with stall_out=1.

Function
REQ-017 The FSM SHALL have three states: RUN, STALL and DRAIN; stall_out SHALL be 1 in STALL and DRAIN and 0 in RUN, registered with the state.
REQ-018 In RUN, if any stall_req bit or buf_full is 1, the next state SHALL be STALL; stall_out therefore rises exactly 1 cycle after the request is sampled.
REQ-019 On RUN->STALL, stall_src SHALL latch the lowest-index set stall_req bit; stall_src SHALL hold that value until the next RUN->STALL transition.
REQ-020 A stall counter SHALL clear on STALL entry and increment each STALL cycle.
REQ-021 STALL SHALL be left only when stall_req==0 and the counter is at least MIN_STALL: to DRAIN if buf_count!=0, else to RUN.
REQ-022 In DRAIN, any stall_req bit set SHALL return the FSM to STALL with stall_src unchanged; otherwise the FSM SHALL go to RUN in the cycle in which buf_count reaches 0.
REQ-023 Write strobe: buf_wr_en = in_valid & ~buf_full & (~out_ready | buf_count!=0 | stall_out).
REQ-024 Read strobe: buf_rd_en = out_ready & (buf_count!=0).
REQ-025 Occupancy: buf_count(next) = buf_count + buf_wr_en - buf_rd_en; simultaneous read and write SHALL leave the count unchanged; the count SHALL never exceed BUF_DEPTH nor wrap below 0.
REQ-026 in_valid=1 while buf_full=1 and buf_rd_en=0 SHALL set overflow; the beat is dropped (no write).
REQ-027 stall_cycles SHALL increment on every cycle with stall_out=1 and hold at 0xFFFF.

Reset
REQ-028 Reset values: state=RUN, stall_out=0, stall_src=0, buf_count=0, overflow=0, stall_cycles=0, stall counter=0.
REQ-029 Reset asserted mid-episode SHALL take priority over all transitions; buffer contents are abandoned (count forced to 0).
REQ-030 Strobes SHALL be 0 during reset.

Structure
REQ-031 The state encoding enum and the stall_cycles width constant SHALL live in a shared package, stall_pkg.
REQ-032 One sub-module is natural: stall_prio_enc (NUM_REQ-bit lowest-index one-hot priority encoder); the rest stays flat.

Verification
REQ-033 Single-cycle request: stall_req=4'b0100 for one cycle, buffer empty -> stall_out=1 for exactly MIN_STALL=2 cycles, stall_src=4'b0100, then RUN.
REQ-034 Simultaneous requests: stall_req=4'b1010 -> stall_src=4'b0010.
REQ-035 Skid fill: out_ready=0, in_valid=1 for 5 cycles, DEPTH=4 -> buf_count reaches 4, stall episode opened with stall_src=0, overflow=1 after the 5th beat.
REQ-036 Drain: count=3, requests released, out_ready=1 -> DRAIN for 3 read cycles, then RUN with buf_count=0.
REQ-037 Re-stall in DRAIN: stall_req=4'b0001 during DRAIN -> back to STALL, stall_src unchanged, stall counter restarts.
REQ-038 Reset mid-STALL with count=2 -> next cycle: RUN, stall_out=0, buf_count=0, stall_cycles=0.
